dmem_write_buffer: RTL and testbench

//  Data-memory-side stage between the single-cycle mips core dmem port and a multi-cycle memory bus.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_write_buffer_wbuf_fifo.sv | 87 ++++++++
 rtl/dmem_write_buffer.sv | 161 ++++++++++++++++
 tb/tb_dmem_write_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory write buffer.
//   state_e : read-path FSM states
//   BUS_RD / BUS_WR : encoding of bus_req_we
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_e;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  // Byte address of a word index (low two bits forced to zero).
  function automatic logic [31:0] word_to_byte(input logic [29:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_write_buffer_wbuf_fifo.sv
// wbuf_fifo: DEPTH-entry store FIFO of {word address, data} with a parallel
// address-match port.
//   clk, rst          clock / async active-high reset
//   push_i, push_*_i  write a new entry at the tail
//   pop_i             retire the head entry
//   head_*_o          current head entry (oldest)
//   full_o, empty_o   occupancy flags
//   match_word_i      word address to look up
//   hit_o, hit_idx_o  some valid entry matches; index of the youngest match
//   rd_idx_i/rd_data_o  combinational data read port
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WW    = 30,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [WW-1:0] push_word_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [WW-1:0] head_word_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o,
  input  logic [WW-1:0] match_word_i,
  output logic          hit_o,
  output logic [PW-1:0] hit_idx_o,
  input  logic [PW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o
);

  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_s;
  logic [WW-1:0] word_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];

  // Pointer and storage update; pointers carry one extra wrap bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        word_mem_q[wr_ptr_q[PW-1:0]] <= push_word_i;
        data_mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign count_s     = wr_ptr_q - rd_ptr_q;
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_word_o = word_mem_q[rd_ptr_q[PW-1:0]];
  assign head_data_o = data_mem_q[rd_ptr_q[PW-1:0]];
  assign rd_data_o   = data_mem_q[rd_idx_i];

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx_s;
    hit_o     = 1'b0;
    hit_idx_o = '0;
    idx_s     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = rd_ptr_q[PW-1:0] + k[PW-1:0];
      if (((PW+1)'(k) < count_s) && (word_mem_q[idx_s] == match_word_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = idx_s;
      end else begin
        hit_o     = hit_o;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posts core stores into a write buffer, forwards loads
// from it, and issues bus reads on load misses while stalling the core.
//   clk, rst                      clock / async active-high reset
//   dmem_we/re/addr/wdata, rdata  single-cycle core data port
//   stall                         core must hold all state this cycle
//   bus_req_*                     valid/ready request channel to memory
//   bus_rsp_valid/rdata           read response (one pulse per read)
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dmem_we,
  input  logic          dmem_re,
  input  logic [AW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_wdata,
  output logic [DW-1:0] dmem_rdata,
  output logic          stall,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic          bus_req_we,
  output logic [AW-1:0] bus_req_addr,
  output logic [DW-1:0] bus_req_wdata,
  input  logic          bus_rsp_valid,
  input  logic [DW-1:0] bus_rsp_rdata
);

  localparam int WW = AW - 2;
  localparam int PW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [WW-1:0] rd_word_q, rd_word_d;
  logic          drain_hold_q, drain_hold_d;

  logic [WW-1:0] core_word_s, head_word_s;
  logic [DW-1:0] head_data_s, hit_data_s;
  logic          full_s, empty_s, hit_s, push_s, pop_s;
  logic [PW-1:0] hit_idx_s;
  logic          read_miss_s, stall_wr_s, fsm_stall_s;
  logic          unused_addr_s;

  assign core_word_s   = dmem_addr[AW-1:2];
  assign unused_addr_s = ^dmem_addr[1:0];
  assign read_miss_s   = dmem_re & ~hit_s;
  assign stall_wr_s    = dmem_we & full_s & ~pop_s;
  assign push_s        = dmem_we & ~stall_wr_s;
  assign stall         = stall_wr_s | fsm_stall_s;

  wbuf_fifo #(.DEPTH(DEPTH), .WW(WW), .DW(DW)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .push_word_i  (core_word_s),
    .push_data_i  (dmem_wdata),
    .pop_i        (pop_s),
    .head_word_o  (head_word_s),
    .head_data_o  (head_data_s),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .match_word_i (core_word_s),
    .hit_o        (hit_s),
    .hit_idx_o    (hit_idx_s),
    .rd_idx_i     (hit_idx_s),
    .rd_data_o    (hit_data_s)
  );

  // FSM next state, bus request muxing and FSM-driven stall.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    rd_word_d     = rd_word_q;
    bus_req_valid = 1'b0;
    bus_req_we    = BUS_RD;
    bus_req_addr  = {rd_word_q, 2'b00};
    bus_req_wdata = '0;
    pop_s         = 1'b0;
    fsm_stall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        // A drain already on the bus must stay until accepted, even if a
        // miss is waiting; otherwise a miss takes the bus first.
        if (drain_hold_q || (!read_miss_s && !empty_s)) begin
          bus_req_valid = 1'b1;
          bus_req_we    = BUS_WR;
          bus_req_addr  = {head_word_s, 2'b00};
          bus_req_wdata = head_data_s;
          pop_s         = bus_req_ready;
          fsm_stall_s   = read_miss_s;
        end else if (read_miss_s) begin
          bus_req_valid = 1'b1;
          bus_req_we    = BUS_RD;
          bus_req_addr  = {core_word_s, 2'b00};
          rd_word_d     = core_word_s;
          fsm_stall_s   = 1'b1;
          state_d       = bus_req_ready ? RD_WAIT : RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        bus_req_valid = 1'b1;
        bus_req_we    = BUS_RD;
        bus_req_addr  = {rd_word_q, 2'b00};
        fsm_stall_s   = 1'b1;
        if (bus_req_ready) begin
          state_d = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        fsm_stall_s = 1'b1;
        if (bus_rsp_valid) begin
          rdata_d = bus_rsp_rdata;
          state_d = RD_DONE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    drain_hold_d = bus_req_valid & (bus_req_we == BUS_WR) & ~bus_req_ready;
  end

  // Load data: captured bus data during RD_DONE, else forwarded FIFO data.
  always_comb begin
    if (state_q == RD_DONE) begin
      dmem_rdata = rdata_q;
    end else if (dmem_re && hit_s) begin
      dmem_rdata = hit_data_s;
    end else begin
      dmem_rdata = '0;
    end
  end

  // FSM and read-path registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rdata_q      <= '0;
      rd_word_q    <= '0;
      drain_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      rd_word_q    <= rd_word_d;
      drain_hold_q <= drain_hold_d;
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
module tb_dmem_write_buffer;

  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_we, dmem_re;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  always #5 clk = ~clk;

  dmem_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .dmem_we       (dmem_we),
    .dmem_re       (dmem_re),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .stall         (stall),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: architectural memory seen by the core, and memory behind the bus.
  logic [31:0] mem_model [256];
  logic [31:0] bus_mem   [256];
  wr_t         wr_exp[$];
  logic [31:0] load_exp[$];

  int ready_mode  = 0;   // 0: low, 1: high, 2: random
  int pulse_req   = 0;   // each increment gives one ready=1 cycle
  int fixed_lat   = 0;   // 0: random response latency 1..4
  logic inject_dead = 1'b0;
  int rd_seq = 0, rd_word_m = 0, rd_lat_m = 1;
  int n_rd = 0, n_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Core-side driver: call at posedge+1, returns at posedge+1 with strobes low.
  task automatic core_op(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] data, output int stalls);
    dmem_we = we; dmem_re = re; dmem_addr = addr; dmem_wdata = data;
    if (we) begin
      mem_model[addr[9:2]] = data;
      wr_exp.push_back(wr_t'{addr[31:2], data});
    end
    if (re) load_exp.push_back(mem_model[addr[9:2]]);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (stalls > 300) begin
        n_checks++; n_fail++;
        $display("FAIL op_timeout: stall high for %0d cycles, expected to drop", stalls);
        break;
      end
    end
    @(posedge clk); #1;
    dmem_we = 1'b0; dmem_re = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (wr_exp.size() != 0 && t < 300) begin
      @(negedge clk); t++;
    end
    check("drain_done", wr_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  // Bus-side agent: ready generation and read responses.
  initial begin
    int seen = 0, cnt = 0, w = 0, pseen = 0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      if (pulse_req != pseen) begin
        pseen = pulse_req; bus_req_ready = 1'b1;
      end else begin
        case (ready_mode)
          0: bus_req_ready = 1'b0;
          1: bus_req_ready = 1'b1;
          default: bus_req_ready = 1'($urandom_range(0, 1));
        endcase
      end
      if (rst) begin
        cnt = 0; seen = rd_seq;
      end else begin
        if (rd_seq != seen) begin
          seen = rd_seq; cnt = rd_lat_m; w = rd_word_m;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus_rsp_valid = 1'b1; bus_rsp_rdata = bus_mem[w];
          end
        end
        if (inject_dead) begin
          bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0000_DEAD;
        end
      end
    end
  end

  // Monitor: protocol stability, drain order, read issue and load data.
  initial begin
    logic pv = 1'b0, pr = 1'b0, pwe = 1'b0;
    logic [31:0] pa = 32'h0, pd = 32'h0;
    wr_t e;
    for (int i = 0; i < 256; i++) bus_mem[i] = 32'hC0DE_0000 + i;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          n_checks++;
          if (!(bus_req_valid && bus_req_we == pwe && bus_req_addr == pa &&
                (!pwe || bus_req_wdata == pd))) begin
            n_fail++;
            $display("FAIL req_stable: got v=%0b we=%0b a=0x%08h d=0x%08h, expected v=1 we=%0b a=0x%08h d=0x%08h",
                     bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, pwe, pa, pd);
          end
        end
        if (bus_req_valid && bus_req_ready) begin
          if (bus_req_we) begin
            if (wr_exp.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL drain_unexpected: got write 0x%08h, expected none", bus_req_addr);
            end else begin
              e = wr_exp.pop_front();
              check("drain_addr", bus_req_addr, {e.word, 2'b00});
              check("drain_data", bus_req_wdata, e.data);
            end
            bus_mem[bus_req_addr[9:2]] = bus_req_wdata;
            n_wr++;
          end else begin
            check("read_addr", bus_req_addr, {dmem_addr[31:2], 2'b00});
            n_rd++;
            rd_word_m = int'(bus_req_addr[9:2]);
            rd_lat_m  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            rd_seq++;
          end
        end
        if (dmem_re && !stall) begin
          if (load_exp.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL load_unexpected: got 0x%08h, expected no load", dmem_rdata);
          end else begin
            check("load_data", dmem_rdata, load_exp.pop_front());
          end
        end
        pv = bus_req_valid; pr = bus_req_ready; pwe = bus_req_we;
        pa = bus_req_addr;  pd = bus_req_wdata;
      end
    end
  end

  initial begin
    int s, rd0, op;
    logic [31:0] a;
    rst = 1'b1; dmem_we = 1'b0; dmem_re = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'hC0DE_0000 + i;

    // Reset values
    @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_valid", {31'h0, bus_req_valid}, 32'h0);
    check("rst_rdata", dmem_rdata, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Store then forward with the bus blocked
    ready_mode = 0; rd0 = n_rd;
    core_op(1'b1, 1'b0, 32'h40, 32'h1234, s);
    core_op(1'b0, 1'b1, 32'h40, 32'h0, s);
    check("fwd_stall_cycles", s, 0);
    check("fwd_no_read", n_rd, rd0);

    // Youngest match wins, drains in order
    core_op(1'b1, 1'b0, 32'h80, 32'hA, s);
    core_op(1'b1, 1'b0, 32'h80, 32'hB, s);
    core_op(1'b0, 1'b1, 32'h83, 32'h0, s);
    check("young_stall_cycles", s, 0);
    ready_mode = 1;
    wait_drain();

    // Full buffer: fifth store stalls until one ready pulse frees a slot
    ready_mode = 0;
    core_op(1'b0, 1'b0, 32'h0, 32'h0, s);
    for (int i = 0; i < 4; i++) core_op(1'b1, 1'b0, 32'h100 + 32'(i*4), 32'h100 + 32'(i), s);
    fork begin @(negedge clk); pulse_req++; end join_none
    core_op(1'b1, 1'b0, 32'h110, 32'h104, s);
    check("full_stall_cycles", s, 1);
    ready_mode = 1;
    wait_drain();

    // Read miss, latency 3
    fixed_lat = 3;
    core_op(1'b0, 1'b1, 32'h3C0, 32'h0, s);
    check("miss_stall_cycles", s, 4);

    // Miss while a drain is pending
    ready_mode = 0; fixed_lat = 2;
    core_op(1'b1, 1'b0, 32'h300, 32'h5A5A_0300, s);
    core_op(1'b0, 1'b0, 32'h0, 32'h0, s);
    fork begin repeat (3) @(posedge clk); ready_mode = 1; end join_none
    rd0 = n_rd;
    core_op(1'b0, 1'b1, 32'h3F0, 32'h0, s);
    check("pend_stall_cycles", s, 7);
    check("pend_read_issued", n_rd, rd0 + 1);
    check("pend_drain_done", wr_exp.size(), 0);

    // Reset mid-run with buffered stores and a late response
    ready_mode = 0; fixed_lat = 0;
    core_op(1'b1, 1'b0, 32'h20, 32'h5555, s);
    core_op(1'b1, 1'b0, 32'h24, 32'h6666, s);
    rst = 1'b1;
    wr_exp.delete(); load_exp.delete();
    @(negedge clk);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    check("midrst_valid", {31'h0, bus_req_valid}, 32'h0);
    check("midrst_rdata", dmem_rdata, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = bus_mem[i];
    ready_mode = 1; inject_dead = 1'b1;
    @(posedge clk); #1; inject_dead = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rsp_stall", {31'h0, stall}, 32'h0);
      check("late_rsp_rdata", dmem_rdata, 32'h0);
      check("flushed_no_drain", {31'h0, bus_req_valid}, 32'h0);
    end
    @(posedge clk); #1;
    core_op(1'b0, 1'b1, 32'h20, 32'h0, s);

    // Randomized traffic over a small aliasing window
    ready_mode = 2;
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 2));
      a  = {24'h0, 3'($urandom_range(0, 7)) , 3'h0, 2'($urandom)} >> 1;
      a  = {a[31:5], a[4:0]};
      if (op == 0) core_op(1'b1, 1'b0, a, $urandom, s);
      else if (op == 1) core_op(1'b0, 1'b1, a, 32'h0, s);
      else core_op(1'b0, 1'b0, 32'h0, 32'h0, s);
    end
    ready_mode = 1;
    wait_drain();
    check("loads_all_returned", load_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
